mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
Top-level instruction sequencer for the microcontroller datapath (R0–R3, P0, ALU A/G registers, shared bus). It fetches 16-bit instructions from program memory and decodes them. It then drives the per-register bus in/out enables cycle by cycle, replacing the standalone per-opcode FSMs (mov, etc.) with one scheduler. That scheduler is the single owner of the bus.

Parameters:
PC_WIDTH, 8, program counter / memory address width
IMM_WIDTH, 6, immediate and parameter field width (fixed at 6 for the 16-bit format)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
run  in  1  level; enables fetching of further instructions
mem_addr  out  PC_WIDTH  program memory address (= pc)
mem_rd  out  1  instruction read request
mem_ack  in  1  memory data valid; ignored unless mem_rd=1
mem_data  in  16  instruction word {opcode[15:12], param1[11:6], param2[5:0]}
reg_in  out  5  one-hot load enables {P0,R3,R2,R1,R0}
reg_out  out  5  one-hot bus drive enables {P0,R3,R2,R1,R0}
imm_out  out  1  drive imm_val onto bus
imm_val  out  6  immediate value
a_in  out  1  load ALU A register from bus
g_in  out  1  load ALU G register with the ALU result
g_out  out  1  drive G onto bus
alu_op  out  1  0=add, 1=sub; valid while g_in=1
done  out  1  one-cycle pulse per retired instruction
halted  out  1  sticky; core is stopped
illegal  out  1  sticky; halt was caused by a bad opcode or register select

Behaviour:
- Reset state (rst=0, asynchronous): state=IDLE, pc=0, IR=0. All outputs are 0, except mem_addr=0.
- Register select: param[5:3] must be 0. param[2:0] 0–3 selects R0–R3; 4 selects P0; 5–7 are invalid.
- Opcodes: 0 NOP, 1 MOV Ri←Rj, 2 MVI Ri←imm(param2), 3 ADD Ri←Ri+Rj, 4 SUB Ri←Ri−Rj, 5 JMP pc←{param1,param2}[PC_WIDTH-1:0], F HALT. All other opcodes are illegal.
- Field roles: i=param1, j=param2.
- FSM states: IDLE, FETCH, DECODE, EX1, EX2, EX3, DONE, HALT.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: mem_rd=1, held until mem_ack. Wait states are unbounded. On ack, IR←mem_data, pc←pc+1 (wraps to 0), go to DECODE.
- DECODE: one cycle, no bus activity. Validate the register fields used by the opcode (MVI: param1 only; JMP/NOP/HALT: none).
  - Invalid register or illegal opcode → HALT with illegal=1.
  - HALT opcode → HALT with illegal=0.
  - NOP → DONE.
  - Otherwise → EX1.
- MOV: EX1 asserts reg_out[j] and reg_in[i] → DONE. i=j is legal and performed.
- MVI: EX1 asserts imm_out=1, imm_val=param2, reg_in[i] → DONE.
- ADD/SUB (3 cycles):
  - EX1: reg_out[i], a_in.
  - EX2: reg_out[j], g_in, alu_op.
  - EX3: g_out, reg_in[i] → DONE.
- JMP: EX1 loads pc; no bus enables → DONE. A JMP overrides the pc+1 from fetch.
- DONE: done=1 for one cycle. Go to FETCH if run=1, else IDLE.
- HALT: halted=1, all bus enables 0. Remains in HALT until rst; run is ignored.
- run deasserted mid-instruction: the current instruction completes (including done), then the FSM goes to IDLE.
- Bus exclusivity: at most one of {reg_out bits, imm_out, g_out} is high in any cycle. reg_in is one-hot or zero.
- All outputs are registered or decoded from the state register only (Moore). There are no combinational paths from inputs to outputs.
- Latency from FETCH ack to done:
  - NOP: 2 cycles.
  - MOV/MVI/JMP: 3 cycles.
  - ADD/SUB: 5 cycles.

Decomposition:
- Shared package/header mc_pkg contains:
  - opcode constants
  - state encodings
  - register index constants (R0=0…P0=4)
  - the instruction field bit positions
- One sub-module, mc_reg_decoder: 6-bit param → 5-bit one-hot + valid. It is instantiated twice (i and j).

Test Plan:
- Reset mid-ADD (in EX2): pull rst low → all enables 0 immediately, pc=0. Release rst with run=1 → fetch from address 0.
- MOV R0←R2 (word 0x1002), mem_ack 2 cycles after mem_rd:
  - EX1: reg_out=00100, reg_in=00001.
  - done pulses 1 cycle later.
  - pc=1.
- ADD R1←R1+R3 (0x3043):
  - EX1: reg_out=00010, a_in=1.
  - EX2: reg_out=01000, g_in=1, alu_op=0.
  - EX3: g_out=1, reg_in=00010.
  - done pulses 1 cycle after EX3.
- MVI P0←0x2A (0x212A):
  - imm_out=1, imm_val=101010, reg_in=10000 for one cycle.
- JMP to 0xFF (0x5FFF) followed by fetch:
  - next mem_addr=0xFF.
  - after that fetch, pc wraps to 0x00.
- Illegal cases:
  - opcode 0x7: halted=1, illegal=1, no further mem_rd while run=1.
  - MOV with param1=000101: halted=1, illegal=1.
  - opcode 0xF: halted=1, illegal=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the microcontroller sequencer: opcodes, FSM states,
// register indices and instruction field positions.
package mc_pkg;

   localparam int INSTR_WIDTH = 16;
   localparam int NUM_REGS    = 5;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int P1_MSB  = 11;
   localparam int P1_LSB  = 6;
   localparam int P2_MSB  = 5;
   localparam int P2_LSB  = 0;

   typedef logic [3:0] opcode_t;

   localparam opcode_t OP_NOP  = 4'h0;
   localparam opcode_t OP_MOV  = 4'h1;
   localparam opcode_t OP_MVI  = 4'h2;
   localparam opcode_t OP_ADD  = 4'h3;
   localparam opcode_t OP_SUB  = 4'h4;
   localparam opcode_t OP_JMP  = 4'h5;
   localparam opcode_t OP_HALT = 4'hF;

   localparam logic [2:0] REG_R0 = 3'd0;
   localparam logic [2:0] REG_R1 = 3'd1;
   localparam logic [2:0] REG_R2 = 3'd2;
   localparam logic [2:0] REG_R3 = 3'd3;
   localparam logic [2:0] REG_P0 = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EX1    = 3'd3,
      EX2    = 3'd4,
      EX3    = 3'd5,
      DONE   = 3'd6,
      HALT   = 3'd7
   } state_e;

endpackage

// File: rtl/mc_reg_decoder.sv
// Maps a 6-bit register-select field onto the one-hot {P0,R3,R2,R1,R0} enables.
module mc_reg_decoder
   import mc_pkg::*;
(
   input  logic [5:0]          param_i,
   output logic [NUM_REGS-1:0] onehot_o,
   output logic                valid_o
);

   assign valid_o  = (param_i[5:3] == 3'b000) && (param_i[2:0] <= REG_P0);
   assign onehot_o = valid_o ? (NUM_REGS'(1) << param_i[2:0]) : '0;

endmodule

// File: rtl/mc_control_unit.sv
// Instruction sequencer: fetches, decodes and drives every bus enable of the
// datapath one cycle at a time. Outputs depend only on state_q and ir_q.
module mc_control_unit
   import mc_pkg::*;
#(
   parameter int PC_WIDTH  = 8,
   parameter int IMM_WIDTH = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run,
   output logic [PC_WIDTH-1:0]    mem_addr,
   output logic                   mem_rd,
   input  logic                   mem_ack,
   input  logic [INSTR_WIDTH-1:0] mem_data,
   output logic [NUM_REGS-1:0]    reg_in,
   output logic [NUM_REGS-1:0]    reg_out,
   output logic                   imm_out,
   output logic [IMM_WIDTH-1:0]   imm_val,
   output logic                   a_in,
   output logic                   g_in,
   output logic                   g_out,
   output logic                   alu_op,
   output logic                   done,
   output logic                   halted,
   output logic                   illegal
);

   state_e                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] ir_q, ir_d;
   logic                   illegal_q, illegal_d;

   opcode_t             opcode;
   logic [5:0]          param1, param2;
   logic [NUM_REGS-1:0] sel_i, sel_j;
   logic                valid_i, valid_j;

   assign opcode = ir_q[OPC_MSB:OPC_LSB];
   assign param1 = ir_q[P1_MSB:P1_LSB];
   assign param2 = ir_q[P2_MSB:P2_LSB];

   mc_reg_decoder u_dec_i (.param_i(param1), .onehot_o(sel_i), .valid_o(valid_i));
   mc_reg_decoder u_dec_j (.param_i(param2), .onehot_o(sel_j), .valid_o(valid_j));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its pre-edge value regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
      end
   end

   // NOTE: every signal gets a default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      mem_rd    = 1'b0;
      reg_in    = '0;
      reg_out   = '0;
      imm_out   = 1'b0;
      imm_val   = '0;
      a_in      = 1'b0;
      g_in      = 1'b0;
      g_out     = 1'b0;
      alu_op    = 1'b0;
      done      = 1'b0;
      halted    = 1'b0;

      unique case (state_q)
         IDLE: if (run) state_d = FETCH;
         FETCH: begin
            mem_rd = 1'b1;
            if (mem_ack) begin
               ir_d    = mem_data;
               pc_d    = pc_q + PC_WIDTH'(1);
               state_d = DECODE;
            end
         end
         DECODE: begin
            // Register fields are validated only where the opcode uses them.
            unique case (opcode)
               OP_NOP:                 state_d = DONE;
               OP_MOV, OP_ADD, OP_SUB: state_d = (valid_i && valid_j) ? EX1 : HALT;
               OP_MVI:                 state_d = valid_i ? EX1 : HALT;
               OP_JMP:                 state_d = EX1;
               OP_HALT:                state_d = HALT;
               default:                state_d = HALT;
            endcase
            illegal_d = (state_d == HALT) && (opcode != OP_HALT);
         end
         EX1: begin
            state_d = DONE;
            unique case (opcode)
               OP_MOV: begin
                  reg_out = sel_j;
                  reg_in  = sel_i;
               end
               OP_MVI: begin
                  imm_out = 1'b1;
                  imm_val = IMM_WIDTH'(param2);
                  reg_in  = sel_i;
               end
               OP_ADD, OP_SUB: begin
                  reg_out = sel_i;
                  a_in    = 1'b1;
                  state_d = EX2;
               end
               OP_JMP:  pc_d = PC_WIDTH'(ir_q[P1_MSB:P2_LSB]);
               default: ;
            endcase
         end
         EX2: begin
            reg_out = sel_j;
            g_in    = 1'b1;
            alu_op  = (opcode == OP_SUB);
            state_d = EX3;
         end
         EX3: begin
            g_out   = 1'b1;
            reg_in  = sel_i;
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = run ? FETCH : IDLE;
         end
         HALT:    halted = 1'b1;
         default: state_d = IDLE;
      endcase
   end

   assign mem_addr = pc_q;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: hand-computed enables checked cycle by
// cycle on the falling edge, inputs driven on the falling edge.
module tb_mc_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic        mem_ack;
   logic [15:0] mem_data;
   logic [4:0]  reg_in, reg_out;
   logic        imm_out;
   logic [5:0]  imm_val;
   logic        a_in, g_in, g_out, alu_op, done, halted, illegal;

   int total = 0;
   int bad   = 0;

   mc_control_unit #(.PC_WIDTH(8), .IMM_WIDTH(6)) dut (
      .clk(clk), .rst(rst), .run(run),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data),
      .reg_in(reg_in), .reg_out(reg_out), .imm_out(imm_out), .imm_val(imm_val),
      .a_in(a_in), .g_in(g_in), .g_out(g_out), .alu_op(alu_op),
      .done(done), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Waits (bounded) for mem_rd, checks the address, then acks after 'delay' cycles.
   task automatic fetch(input logic [15:0] word, input int delay, input logic [7:0] exp_addr);
      for (int n = 0; n < 20 && !mem_rd; n++) step();
      check("fetch_rd", mem_rd, 1);
      check("fetch_addr", mem_addr, exp_addr);
      repeat (delay) step();
      mem_ack  = 1'b1;
      mem_data = word;
      step();
      mem_ack  = 1'b0;
      mem_data = 16'h0000;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   function automatic logic [31:0] all_outs();
      return {mem_rd, reg_in, reg_out, imm_out, imm_val, a_in, g_in, g_out, alu_op, done, halted, illegal};
   endfunction

   int rd_seen;

   initial begin
      rst = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_data = 16'h0000;
      step();
      check("reset_outs", all_outs(), 0);
      check("reset_addr", mem_addr, 0);
      rst = 1'b1;
      step(); step();
      check("idle_no_rd", mem_rd, 0);

      // MOV R0<-R2, ack two cycles after mem_rd
      run = 1'b1;
      fetch(16'h1002, 2, 8'h00);
      check("mov_decode_quiet", {reg_in, reg_out, imm_out, a_in, g_in, g_out, done}, 0);
      step();
      check("mov_ex1_out", reg_out, 5'b00100);
      check("mov_ex1_in", reg_in, 5'b00001);
      step();
      check("mov_done", done, 1);
      check("mov_pc", mem_addr, 8'h01);

      // ADD R1<-R1+R3
      fetch(16'h3043, 0, 8'h01);
      step();
      check("add_ex1_out", reg_out, 5'b00010);
      check("add_ex1_a", a_in, 1);
      step();
      check("add_ex2_out", reg_out, 5'b01000);
      check("add_ex2_g", {g_in, alu_op}, 2'b10);
      step();
      check("add_ex3", {g_out, reg_in, reg_out}, {1'b1, 5'b00010, 5'b00000});
      step();
      check("add_done", done, 1);

      // SUB R2<-R2-R0
      fetch(16'h4080, 1, 8'h02);
      step();
      check("sub_ex1_out", reg_out, 5'b00100);
      step();
      check("sub_ex2", {reg_out, g_in, alu_op}, {5'b00001, 2'b11});
      step();
      check("sub_ex3_in", reg_in, 5'b00100);
      step();
      check("sub_done", done, 1);

      // MVI P0<-0x2A
      fetch(16'h212A, 0, 8'h03);
      step();
      check("mvi_p0", {imm_out, imm_val, reg_in, reg_out}, {1'b1, 6'h2A, 5'b10000, 5'b00000});
      step();
      check("mvi_p0_done", {done, imm_out}, 2'b10);

      // MVI R1<-0x3F: param2 is data, not a register select
      fetch(16'h207F, 0, 8'h04);
      step();
      check("mvi_r1", {imm_out, imm_val, reg_in}, {1'b1, 6'h3F, 5'b00010});
      step();
      check("mvi_r1_done", {done, halted}, 2'b10);

      // NOP: done two cycles after the ack edge
      fetch(16'h0000, 0, 8'h05);
      step();
      check("nop_done", done, 1);

      // JMP 0xFF, then fetch there and wrap
      fetch(16'h5FFF, 0, 8'h06);
      step();
      check("jmp_ex1_quiet", {reg_in, reg_out, imm_out, g_out}, 0);
      step();
      check("jmp_done", done, 1);
      check("jmp_pc", mem_addr, 8'hFF);
      fetch(16'h10C3, 0, 8'hFF);
      check("pc_wrap", mem_addr, 8'h00);
      run = 1'b0;
      step();
      check("mov_same", {reg_out, reg_in}, {5'b01000, 5'b01000});
      step();
      check("stop_done", done, 1);
      step(); step();
      check("stop_idle", {mem_rd, done}, 0);

      // Asynchronous reset in the middle of ADD EX2
      run = 1'b1;
      fetch(16'h3043, 0, 8'h00);
      step(); step();
      check("pre_rst_g_in", g_in, 1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_outs", all_outs(), 0);
      check("async_rst_pc", mem_addr, 0);
      step();
      rst = 1'b1;

      // Illegal opcode 7 after reset: fetch must restart at 0
      fetch(16'h7000, 0, 8'h00);
      step();
      check("op7_flags", {halted, illegal}, 2'b11);
      rd_seen = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (mem_rd) rd_seen++;
      end
      check("op7_no_fetch", rd_seen, 0);
      check("op7_sticky", {halted, illegal, done}, 3'b110);

      do_reset();
      check("rst_clears_halt", {halted, illegal}, 0);

      // MOV with param1 = 5 (invalid register)
      fetch(16'h1140, 0, 8'h00);
      step();
      check("mov_bad_i", {halted, illegal, reg_in}, {2'b11, 5'b00000});

      // MOV with param2[5:3] nonzero
      do_reset();
      fetch(16'h1008, 0, 8'h00);
      step();
      check("mov_bad_j", {halted, illegal, reg_out}, {2'b11, 5'b00000});

      // HALT opcode: halted without illegal
      do_reset();
      fetch(16'hF000, 0, 8'h00);
      step();
      check("halt_op", {halted, illegal}, 2'b10);
      step(); step();
      check("halt_hold", {halted, mem_rd, reg_in, reg_out}, {1'b1, 11'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
